fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program-counter `pointer`. It consumes the pointer's current address, requests the instruction word from instruction memory over a req/ack handshake, and steps the pointer forward on each accepted fetch. Fetched words are buffered with their PC in a 2-entry queue and delivered to decode over a valid/ready handshake. A redirect (`flush`) discards buffered and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_instr_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit_pkg                                               |
// | Description : Shared constants and FSM encoding for the instruction fetch  |
// |               stage and its instruction queue.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

   // Width of program counter and instruction words.
   localparam int WORD_SIZE = 32;

   // Signed increment handed to the pointer on a sequential advance.
   localparam int PC_STEP = 4;

   // Instruction queue entries; must be a power of two so pointers wrap freely.
   localparam int DEPTH = 2;

   // Queue pointer and occupancy widths derived from DEPTH.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Fetch FSM encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_instr_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_queue                                                  |
// | Description : DEPTH-entry FIFO of {pc, instr} pairs with push, pop and a   |
// |               clear that overrides both. Head outputs are read straight    |
// |               from storage registers through the registered read pointer.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_queue
   import fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 push,
   input  logic [WORD_SIZE-1:0] push_pc,
   input  logic [WORD_SIZE-1:0] push_instr,
   input  logic                 pop_ready,
   output logic                 head_valid,
   output logic [WORD_SIZE-1:0] head_pc,
   output logic [WORD_SIZE-1:0] head_instr,
   output logic [CNT_W-1:0]     count
);

   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic [WORD_SIZE-1:0] r_pc_mem    [DEPTH];
   logic [WORD_SIZE-1:0] r_instr_mem [DEPTH];
   logic                 w_pop;

   assign head_valid = (r_count != '0);
   assign w_pop      = head_valid && pop_ready;
   assign count      = r_count;
   assign head_pc    = r_pc_mem[r_rd_ptr];
   assign head_instr = r_instr_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; clear wins over any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      // Each slot captures the pushed pair when the write pointer selects it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= '0;
         end else if (push && !clear && (r_wr_ptr == PTR_W'(i))) begin
            r_pc_mem[i]    <= push_pc;
            r_instr_mem[i] <= push_instr;
         end
      end
   end

endmodule : instr_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Issues one outstanding req/ack      |
// |               fetch at the pointer's address, steps the pointer on each    |
// |               accepted word and buffers {pc, instr} for decode. A flush    |
// |               discards the queue and any in-flight fetch.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] pc,
   output logic                 pc_update,
   output logic [WORD_SIZE-1:0] pc_step,
   input  logic                 flush,
   output logic                 mem_req,
   output logic [WORD_SIZE-1:0] mem_addr,
   input  logic                 mem_ack,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [WORD_SIZE-1:0] instr,
   output logic [WORD_SIZE-1:0] instr_pc
);

   fetch_state_t         r_state;
   fetch_state_t         w_next_state;
   logic [WORD_SIZE-1:0] r_mem_addr;
   logic                 w_latch;
   logic                 w_push;
   logic                 w_slot_free;
   logic [CNT_W-1:0]     w_count;

   // A request is only launched when a slot is free, so an ack can always push.
   assign w_slot_free = (w_count < CNT_W'(DEPTH));

   // The request is held through DROP: memory is never left with a withdrawn req.
   assign mem_req   = (r_state != IDLE);
   assign mem_addr  = r_mem_addr;
   assign pc_update = w_push;
   assign pc_step   = WORD_SIZE'(PC_STEP);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus the latch/push strobes for the current cycle.
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_push       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!flush && w_slot_free) begin
               w_latch      = 1'b1;
               w_next_state = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               w_push       = !flush;
               w_next_state = IDLE;
            end else if (flush) begin
               w_next_state = DROP;
            end
         end
         DROP: begin
            if (mem_ack) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Fetch address is captured once in IDLE and held for the whole request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_addr <= '0;
      end else if (w_latch) begin
         r_mem_addr <= pc;
      end
   end

   instr_queue u_instr_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (flush),
      .push       (w_push),
      .push_pc    (r_mem_addr),
      .push_instr (mem_rdata),
      .pop_ready  (instr_ready),
      .head_valid (instr_valid),
      .head_pc    (instr_pc),
      .head_instr (instr),
      .count      (w_count)
   );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Directed bench for fetch_unit with a pointer model and a     |
// |               programmable-latency memory responder.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc = 32'h0;
   logic        pc_update;
   logic [31:0] pc_step;
   logic        flush;
   logic [31:0] flush_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   logic        auto_ack;
   logic        man_ack;
   int          latency;
   int          wait_cnt = 0;

   int          vectors = 0;
   int          miscompares = 0;
   int          upd_n = 0;
   int          recv_n = 0;
   int          glitch_n = 0;
   logic [31:0] recv_pc  [64];
   logic [31:0] recv_ins [64];
   logic        held = 1'b0;
   logic [31:0] held_addr = 32'h0;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .pc_update   (pc_update),
      .pc_step     (pc_step),
      .flush       (flush),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   always #5 clk = ~clk;

   // Memory answers after `latency` wait cycles with a word tagged by its address.
   assign mem_ack   = man_ack | (auto_ack & mem_req & (wait_cnt >= latency));
   assign mem_rdata = 32'hAAAA0000 + mem_addr;

   // Pointer model, responder wait counter and observation logs.
   always @(posedge clk) begin
      if (flush) pc <= flush_pc;
      else if (pc_update) pc <= pc + pc_step;
      if (pc_update) upd_n <= upd_n + 1;
      wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
      if (instr_valid && instr_ready && recv_n < 64) begin
         recv_pc[recv_n]  <= instr_pc;
         recv_ins[recv_n] <= instr;
         recv_n           <= recv_n + 1;
      end
      if (mem_req && held && (mem_addr !== held_addr)) glitch_n <= glitch_n + 1;
      held      <= mem_req && !mem_ack;
      held_addr <= mem_addr;
   end

   task automatic apply_reset(input logic [31:0] p, input logic aa, input int lat, input logic rdy);
      @(negedge clk);
      rst_n = 1'b0; flush = 1'b1; flush_pc = p; auto_ack = 1'b0; man_ack = 1'b0; instr_ready = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      auto_ack = aa; latency = lat; instr_ready = rdy; rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
      vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
      vectors++; if (pc_update !== 1'b0) begin miscompares++; $display("FAIL reset_pc_update: got %0h want 0", pc_update); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %0h want 0", instr_valid); end
      vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %0h want 0", instr); end
      vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %0h want 0", instr_pc); end
      vectors++; if (pc_step !== 32'h4) begin miscompares++; $display("FAIL reset_pc_step: got %0h want 4", pc_step); end
   endtask

   task automatic test_sequential();
      int r0, u0, g0;
      apply_reset(32'h0, 1'b1, 0, 1'b1);
      r0 = recv_n; u0 = upd_n; g0 = glitch_n;
      for (int i = 0; i < 40 && recv_n < r0 + 3; i++) @(negedge clk);
      auto_ack = 1'b0;
      vectors++;
      if (recv_n < r0 + 3) begin
         miscompares++; $display("FAIL seq_timeout: got %0d words want 3", recv_n - r0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (recv_pc[r0+k] !== 32'(4*k) || recv_ins[r0+k] !== 32'hAAAA0000 + 32'(4*k)) begin
               miscompares++;
               $display("FAIL seq_word%0d: got pc %0h instr %0h want pc %0h instr %0h", k, recv_pc[r0+k], recv_ins[r0+k], 4*k, 32'hAAAA0000 + 32'(4*k));
            end
         end
         vectors++; if (upd_n - u0 !== 3) begin miscompares++; $display("FAIL seq_pc_updates: got %0d want 3", upd_n - u0); end
         vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin miscompares++; $display("FAIL seq_next_req: got req %0h addr %0h want req 1 addr c", mem_req, mem_addr); end
      end
      vectors++; if (glitch_n !== g0) begin miscompares++; $display("FAIL seq_addr_stable: got %0d changes want 0", glitch_n - g0); end
   endtask

   task automatic test_backpressure();
      int r0, u0;
      apply_reset(32'h0, 1'b1, 0, 1'b0);
      r0 = recv_n; u0 = upd_n;
      repeat (8) @(negedge clk);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_low: got %0h want 0", mem_req); end
      vectors++; if (upd_n - u0 !== 2) begin miscompares++; $display("FAIL bp_buffered: got %0d want 2", upd_n - u0); end
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hAAAA0000) begin miscompares++; $display("FAIL bp_head: got v %0h pc %0h instr %0h want v 1 pc 0 instr aaaa0000", instr_valid, instr_pc, instr); end
      instr_ready = 1'b1;
      for (int i = 0; i < 40 && recv_n < r0 + 3; i++) @(negedge clk);
      vectors++;
      if (recv_n < r0 + 3) begin
         miscompares++; $display("FAIL bp_timeout: got %0d words want 3", recv_n - r0);
      end else begin
         vectors++; if (recv_pc[r0] !== 32'h0 || recv_pc[r0+1] !== 32'h4 || recv_pc[r0+2] !== 32'h8) begin miscompares++; $display("FAIL bp_order: got %0h %0h %0h want 0 4 8", recv_pc[r0], recv_pc[r0+1], recv_pc[r0+2]); end
         vectors++; if (recv_ins[r0+1] !== 32'hAAAA0004) begin miscompares++; $display("FAIL bp_instr1: got %0h want aaaa0004", recv_ins[r0+1]); end
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_flush_drop();
      int r0, u0, g0;
      apply_reset(32'h0, 1'b1, 3, 1'b1);
      r0 = recv_n; u0 = upd_n; g0 = glitch_n;
      repeat (2) @(negedge clk);
      flush = 1'b1; flush_pc = 32'h100;
      @(negedge clk);
      flush = 1'b0;
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL drop_hold: got req %0h addr %0h want req 1 addr 0", mem_req, mem_addr); end
      @(negedge clk);
      vectors++; if (pc_update !== 1'b0) begin miscompares++; $display("FAIL drop_no_update: got %0h want 0", pc_update); end
      @(negedge clk);
      vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got req %0h valid %0h want 0 0", mem_req, instr_valid); end
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_redirect: got req %0h addr %0h want req 1 addr 100", mem_req, mem_addr); end
      vectors++; if (upd_n !== u0) begin miscompares++; $display("FAIL drop_updates: got %0d want 0", upd_n - u0); end
      for (int i = 0; i < 40 && recv_n < r0 + 1; i++) @(negedge clk);
      vectors++;
      if (recv_n < r0 + 1) begin
         miscompares++; $display("FAIL drop_timeout: got %0d words want 1", recv_n - r0);
      end else if (recv_pc[r0] !== 32'h100 || recv_ins[r0] !== 32'hAAAA0100) begin
         miscompares++; $display("FAIL drop_first_word: got pc %0h instr %0h want pc 100 instr aaaa0100", recv_pc[r0], recv_ins[r0]);
      end
      vectors++; if (glitch_n !== g0) begin miscompares++; $display("FAIL drop_addr_stable: got %0d changes want 0", glitch_n - g0); end
      auto_ack = 1'b0;
   endtask

   task automatic test_flush_collide();
      int r0, u0;
      // Queue full, flush with a pop and a stray ack in the same cycle.
      apply_reset(32'h0, 1'b1, 0, 1'b0);
      r0 = recv_n; u0 = upd_n;
      repeat (6) @(negedge clk);
      vectors++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL full_state: got valid %0h req %0h want 1 0", instr_valid, mem_req); end
      auto_ack = 1'b0; man_ack = 1'b1; flush = 1'b1; flush_pc = 32'h200; instr_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; man_ack = 1'b0; instr_ready = 1'b0;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL full_flush_valid: got %0h want 0", instr_valid); end
      vectors++; if (recv_n - r0 !== 1 || recv_pc[r0] !== 32'h0) begin miscompares++; $display("FAIL full_flush_pop: got %0d words pc %0h want 1 word pc 0", recv_n - r0, recv_pc[r0]); end
      vectors++; if (upd_n - u0 !== 2) begin miscompares++; $display("FAIL full_flush_updates: got %0d want 2", upd_n - u0); end
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin miscompares++; $display("FAIL full_flush_resume: got valid %0h req %0h addr %0h want 0 1 200", instr_valid, mem_req, mem_addr); end

      // One word queued, flush coincides with ack and pop while in REQ.
      apply_reset(32'h0, 1'b1, 0, 1'b0);
      r0 = recv_n; u0 = upd_n;
      repeat (3) @(negedge clk);
      flush = 1'b1; flush_pc = 32'h200; instr_ready = 1'b1;
      #1;
      vectors++; if (pc_update !== 1'b0 || mem_ack !== 1'b1) begin miscompares++; $display("FAIL ack_flush_update: got upd %0h ack %0h want 0 1", pc_update, mem_ack); end
      @(negedge clk);
      flush = 1'b0;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL ack_flush_valid: got %0h want 0", instr_valid); end
      vectors++; if (recv_n - r0 !== 1 || recv_pc[r0] !== 32'h0) begin miscompares++; $display("FAIL ack_flush_pop: got %0d words pc %0h want 1 word pc 0", recv_n - r0, recv_pc[r0]); end
      vectors++; if (upd_n - u0 !== 1) begin miscompares++; $display("FAIL ack_flush_updates: got %0d want 1", upd_n - u0); end
      for (int i = 0; i < 40 && recv_n < r0 + 2; i++) @(negedge clk);
      vectors++;
      if (recv_n < r0 + 2) begin
         miscompares++; $display("FAIL ack_flush_timeout: got %0d words want 2", recv_n - r0);
      end else if (recv_pc[r0+1] !== 32'h200 || recv_ins[r0+1] !== 32'hAAAA0200) begin
         miscompares++; $display("FAIL ack_flush_resume: got pc %0h instr %0h want pc 200 instr aaaa0200", recv_pc[r0+1], recv_ins[r0+1]);
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_reset_mid_request();
      int r0, u0;
      apply_reset(32'h40, 1'b0, 0, 1'b1);
      r0 = recv_n; u0 = upd_n;
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL rmid_req: got req %0h addr %0h want 1 40", mem_req, mem_addr); end
      rst_n = 1'b0;
      #1;
      vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got req %0h addr %0h valid %0h want 0 0 0", mem_req, mem_addr, instr_valid); end
      @(negedge clk);
      rst_n = 1'b1; man_ack = 1'b1;
      #1;
      vectors++; if (pc_update !== 1'b0) begin miscompares++; $display("FAIL rmid_late_ack: got %0h want 0", pc_update); end
      @(negedge clk);
      man_ack = 1'b0;
      vectors++; if (upd_n !== u0 || instr_valid !== 1'b0 || recv_n !== r0) begin miscompares++; $display("FAIL rmid_ignored: got upd %0d valid %0h words %0d want 0 0 0", upd_n - u0, instr_valid, recv_n - r0); end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL rmid_restart: got req %0h addr %0h want 1 40", mem_req, mem_addr); end
      auto_ack = 1'b1;
      for (int i = 0; i < 40 && recv_n < r0 + 1; i++) @(negedge clk);
      vectors++;
      if (recv_n < r0 + 1) begin
         miscompares++; $display("FAIL rmid_timeout: got %0d words want 1", recv_n - r0);
      end else if (recv_pc[r0] !== 32'h40 || recv_ins[r0] !== 32'hAAAA0040) begin
         miscompares++; $display("FAIL rmid_word: got pc %0h instr %0h want pc 40 instr aaaa0040", recv_pc[r0], recv_ins[r0]);
      end
      auto_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; auto_ack = 1'b0; man_ack = 1'b0;
      latency = 0; instr_ready = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_flush_drop();
      test_flush_collide();
      test_reset_mid_request();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
